// File: rtl/fft_frame_tx.sv
// rtl/fft_frame_tx.sv - serial-to-parallel 16-bin FFT frame producer, double-buffered
module fft_frame_tx #(
    parameter int BIT_REV    = 0,
    parameter int MAX_FRAMES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_d,
    input  logic        flush,
    output logic        in_ready,
    output logic        fft_valid,
    output logic [31:0] fft_d0,
    output logic [31:0] fft_d1,
    output logic [31:0] fft_d2,
    output logic [31:0] fft_d3,
    output logic [31:0] fft_d4,
    output logic [31:0] fft_d5,
    output logic [31:0] fft_d6,
    output logic [31:0] fft_d7,
    output logic [31:0] fft_d8,
    output logic [31:0] fft_d9,
    output logic [31:0] fft_d10,
    output logic [31:0] fft_d11,
    output logic [31:0] fft_d12,
    output logic [31:0] fft_d13,
    output logic [31:0] fft_d14,
    output logic [31:0] fft_d15,
    output logic        frames_done
);

    // Frame counter is at least 7 bits so an unlimited build wraps freely.
    localparam int FCNT_W = ($clog2(MAX_FRAMES + 1) > 7) ? $clog2(MAX_FRAMES + 1) : 7;
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(MAX_FRAMES);

    function automatic logic [3:0] rev4(input logic [3:0] v);
        return {v[0], v[1], v[2], v[3]};
    endfunction

    logic [3:0]        idx_q, idx_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic [31:0]       stage_q [16];
    logic [31:0]       stage_d [16];
    logic [31:0]       out_q   [16];
    logic [31:0]       out_d   [16];
    logic              fft_valid_q, fft_valid_d;
    logic              frames_done_q, frames_done_d;
    logic              in_ready_q, in_ready_d;
    logic              accept;
    logic              last;
    logic [3:0]        slot;

    // Accept qualification and the staging slot for the current sample.
    always_comb begin
        accept = in_valid & in_ready_q & ~flush;
        last   = accept & (idx_q == 4'd15);
        slot   = (BIT_REV != 0) ? rev4(idx_q) : idx_q;
    end

    // Staging write; stage_d doubles as the completed frame so the 16th sample bypasses the buffer.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            stage_d[i] = stage_q[i];
        end
        if (accept) begin
            stage_d[slot] = in_d;
        end
    end

    // Output bank only changes on a completion edge; sample 0 of the next frame never touches it.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            out_d[i] = last ? stage_d[i] : out_q[i];
        end
    end

    // Sample index, frame count, strobe and frame-limit control.
    always_comb begin
        idx_d         = idx_q;
        fcnt_d        = fcnt_q;
        fft_valid_d   = last;
        frames_done_d = frames_done_q;
        if (flush) begin
            idx_d = 4'd0;
        end else if (accept) begin
            idx_d = idx_q + 4'd1;
        end
        if (last) begin
            fcnt_d = fcnt_q + 1'b1;
            if ((MAX_FRAMES != 0) && (fcnt_d == FCNT_LAST)) begin
                frames_done_d = 1'b1;
            end
        end
        in_ready_d = ~frames_done_d;
    end

    // Staging buffer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) stage_q[i] <= '0;
        end else begin
            for (int i = 0; i < 16; i++) stage_q[i] <= stage_d[i];
        end
    end

    // Output frame registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) out_q[i] <= '0;
        end else begin
            for (int i = 0; i < 16; i++) out_q[i] <= out_d[i];
        end
    end

    // Control registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q         <= 4'd0;
            fcnt_q        <= '0;
            fft_valid_q   <= 1'b0;
            frames_done_q <= 1'b0;
            in_ready_q    <= 1'b1;
        end else begin
            idx_q         <= idx_d;
            fcnt_q        <= fcnt_d;
            fft_valid_q   <= fft_valid_d;
            frames_done_q <= frames_done_d;
            in_ready_q    <= in_ready_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign fft_valid   = fft_valid_q;
    assign frames_done = frames_done_q;
    assign fft_d0      = out_q[0];
    assign fft_d1      = out_q[1];
    assign fft_d2      = out_q[2];
    assign fft_d3      = out_q[3];
    assign fft_d4      = out_q[4];
    assign fft_d5      = out_q[5];
    assign fft_d6      = out_q[6];
    assign fft_d7      = out_q[7];
    assign fft_d8      = out_q[8];
    assign fft_d9      = out_q[9];
    assign fft_d10     = out_q[10];
    assign fft_d11     = out_q[11];
    assign fft_d12     = out_q[12];
    assign fft_d13     = out_q[13];
    assign fft_d14     = out_q[14];
    assign fft_d15     = out_q[15];

endmodule
